// File: rtl/rgb_pkg.sv
// Shared encodings for the RGB LED sequencer: command modes, FSM states and
// the colour-word width macro (3 channels of NBPC bits, {R,G,B}).
`ifndef RGB_PKG_SV
`define RGB_PKG_SV

`define RGB_COLOR_W(nbpc) (3*(nbpc))

package rgb_pkg;

    typedef enum logic [1:0] {
        MODE_OFF   = 2'd0,
        MODE_SOLID = 2'd1,
        MODE_BLINK = 2'd2,
        MODE_FADE  = 2'd3
    } mode_e;

    localparam logic [2:0] S_OFF       = 3'd0;
    localparam logic [2:0] S_SOLID     = 3'd1;
    localparam logic [2:0] S_BLINK_ON  = 3'd2;
    localparam logic [2:0] S_BLINK_OFF = 3'd3;
    localparam logic [2:0] S_FADE      = 3'd4;

endpackage

`endif

// File: rtl/rgb_ctrl_if.sv
// Command handshake and PWM-driver output bundle of the RGB sequencer.
// master = command source / PWM consumer side, slave = rgb_ctrl.
interface rgb_ctrl_if #(
    parameter int NBPC = 8
);
    logic                           cmd_valid;
    logic                           cmd_ready;
    logic [1:0]                     cmd_mode;
    logic [`RGB_COLOR_W(NBPC)-1:0]  cmd_color;
    logic [7:0]                     cmd_period;
    logic [`RGB_COLOR_W(NBPC)-1:0]  color;
    logic                           en;

    modport master (
        output cmd_valid, cmd_mode, cmd_color, cmd_period,
        input  cmd_ready, color, en
    );

    modport slave (
        input  cmd_valid, cmd_mode, cmd_color, cmd_period,
        output cmd_ready, color, en
    );
endinterface

// File: rtl/rgb_ctrl_step.sv
// One colour-channel stepper: moves the current value 1 LSB toward the target
// on a step strobe, saturating at the target (never wraps).
module rgb_ctrl_step #(
    parameter int NBPC = 8
) (
    input  logic [NBPC-1:0] cur_i,
    input  logic [NBPC-1:0] tgt_i,
    input  logic            step_i,
    output logic [NBPC-1:0] nxt_o,
    output logic            done_o
);

    always_comb begin
        nxt_o = cur_i;
        if (step_i) begin
            if (cur_i < tgt_i) begin
                nxt_o = cur_i + NBPC'(1);
            end else if (cur_i > tgt_i) begin
                nxt_o = cur_i - NBPC'(1);
            end
        end
    end

    assign done_o = (nxt_o == tgt_i);

endmodule

// File: rtl/rgb_ctrl.sv
// RGB LED sequencer: off / solid / blink / linear fade driven by a tick prescaler.
// Optional idle auto-off is built when RGB_CTRL_TIMEOUT_EN is defined.
module rgb_ctrl
    import rgb_pkg::*;
#(
    parameter int NBPC          = 8,
    parameter int TICK_DIV      = 120000
`ifdef RGB_CTRL_TIMEOUT_EN
    ,
    parameter int TIMEOUT_TICKS = 255
`endif
) (
    input  logic       clk,
    input  logic       rst,
    rgb_ctrl_if.slave  bus
);

    localparam int CW = `RGB_COLOR_W(NBPC);
    localparam int PW = $clog2(TICK_DIV);

    logic [2:0]    state_q, state_d;
    logic [CW-1:0] color_q, color_d;
    logic [CW-1:0] target_q, target_d;
    logic          en_q, en_d;
    logic [7:0]    period_q, period_d;
    logic [7:0]    tcnt_q, tcnt_d;
    logic [PW-1:0] presc_q, presc_d;
`ifdef RGB_CTRL_TIMEOUT_EN
    logic [7:0]    idle_q, idle_d;
`endif

    logic          tick;
    logic          phase_evt;
    logic          timed_state;
    logic [CW-1:0] step_color;
    logic [2:0]    ch_done;

    assign bus.cmd_ready = (state_q != S_FADE);
    assign bus.color     = color_q;
    assign bus.en        = en_q;

    assign tick        = (presc_q == PW'(TICK_DIV - 1));
    assign timed_state = (state_q == S_BLINK_ON) || (state_q == S_BLINK_OFF) || (state_q == S_FADE);
    // period_q is already clamped to >= 1, so the compare never needs a zero case
    assign phase_evt   = tick && timed_state && ((tcnt_q + 8'd1) == period_q);

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_ch
            rgb_ctrl_step #(
                .NBPC (NBPC)
            ) u_step (
                .cur_i  (color_q[gi*NBPC +: NBPC]),
                .tgt_i  (target_q[gi*NBPC +: NBPC]),
                .step_i (phase_evt),
                .nxt_o  (step_color[gi*NBPC +: NBPC]),
                .done_o (ch_done[gi])
            );
        end
    endgenerate

    always_comb begin
        state_d  = state_q;
        color_d  = color_q;
        target_d = target_q;
        en_d     = en_q;
        period_d = period_q;
        presc_d  = tick ? '0 : presc_q + PW'(1);
        tcnt_d   = tcnt_q;
`ifdef RGB_CTRL_TIMEOUT_EN
        idle_d   = idle_q;
`endif

        if (timed_state && tick) begin
            tcnt_d = phase_evt ? 8'd0 : tcnt_q + 8'd1;
        end

        case (state_q)
            S_BLINK_ON: begin
                if (phase_evt) begin
                    state_d = S_BLINK_OFF;
                    color_d = '0;
                end
            end
            S_BLINK_OFF: begin
                if (phase_evt) begin
                    state_d = S_BLINK_ON;
                    color_d = target_q;
                end
            end
            S_FADE: begin
                color_d = step_color;
                if (&ch_done) begin
                    state_d = S_SOLID;
                    tcnt_d  = 8'd0;
                end
            end
            default: ;
        endcase

`ifdef RGB_CTRL_TIMEOUT_EN
        if ((state_q == S_SOLID) || (state_q == S_BLINK_ON) || (state_q == S_BLINK_OFF)) begin
            if (tick) begin
                if ((idle_q + 8'd1) == 8'(TIMEOUT_TICKS)) begin
                    state_d = S_OFF;
                    color_d = '0;
                    en_d    = 1'b0;
                    idle_d  = 8'd0;
                    tcnt_d  = 8'd0;
                end else begin
                    idle_d = idle_q + 8'd1;
                end
            end
        end else begin
            idle_d = 8'd0;
        end
`endif

        // An accepted command overrides every timed event in the same cycle
        if (bus.cmd_valid && bus.cmd_ready) begin
            presc_d  = '0;
            tcnt_d   = 8'd0;
            period_d = (bus.cmd_period == 8'd0) ? 8'd1 : bus.cmd_period;
            target_d = bus.cmd_color;
`ifdef RGB_CTRL_TIMEOUT_EN
            idle_d   = 8'd0;
`endif
            case (mode_e'(bus.cmd_mode))
                MODE_SOLID: begin
                    state_d = S_SOLID;
                    color_d = bus.cmd_color;
                    en_d    = 1'b1;
                end
                MODE_BLINK: begin
                    state_d = S_BLINK_ON;
                    color_d = bus.cmd_color;
                    en_d    = 1'b1;
                end
                MODE_FADE: begin
                    state_d = (bus.cmd_color == color_q) ? S_SOLID : S_FADE;
                    en_d    = 1'b1;
                end
                default: begin
                    state_d = S_OFF;
                    color_d = '0;
                    en_d    = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_OFF;
            color_q  <= '0;
            target_q <= '0;
            en_q     <= 1'b0;
            period_q <= 8'd0;
            tcnt_q   <= 8'd0;
            presc_q  <= '0;
`ifdef RGB_CTRL_TIMEOUT_EN
            idle_q   <= 8'd0;
`endif
        end else begin
            state_q  <= state_d;
            color_q  <= color_d;
            target_q <= target_d;
            en_q     <= en_d;
            period_q <= period_d;
            tcnt_q   <= tcnt_d;
            presc_q  <= presc_d;
`ifdef RGB_CTRL_TIMEOUT_EN
            idle_q   <= idle_d;
`endif
        end
    end

endmodule

// File: tb/tb_rgb_ctrl.sv
// Self-checking bench for rgb_ctrl (NBPC=8, TICK_DIV=4): directed steps plus
// random commands checked against a cycles-since-acceptance reference model.
module tb_rgb_ctrl;
    import rgb_pkg::*;

    localparam int TD = 4;
`ifdef RGB_CTRL_TIMEOUT_EN
    localparam int TO = 3;
`endif

    logic clk;
    logic rst;
    int   n_cmp;
    int   n_mis;

    rgb_ctrl_if #(.NBPC(8)) bus ();

    rgb_ctrl #(
        .NBPC          (8),
        .TICK_DIV      (TD)
`ifdef RGB_CTRL_TIMEOUT_EN
        ,
        .TIMEOUT_TICKS (TO)
`endif
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected {cmd_ready, en, color} j edges after the accepting edge
    function automatic logic [25:0] model(input int m, input logic [23:0] s,
                                          input logic [23:0] t, input int p, input int j);
        int tp, n, d, maxd, mv, sc, tc, idle0;
        logic [23:0] c;
        logic rdy;
        tp = TD * ((p == 0) ? 1 : p);
        n = j / tp;
        rdy = 1'b1;
        idle0 = 0;
        c = t;
        if (m == 0) return {1'b1, 1'b0, 24'h0};
        if (m == 2 && (n % 2) == 1) c = 24'h0;
        if (m == 3) begin
            maxd = 0;
            for (int ch = 0; ch < 3; ch++) begin
                sc = int'(s[ch*8 +: 8]);
                tc = int'(t[ch*8 +: 8]);
                d  = (tc > sc) ? tc - sc : sc - tc;
                mv = (n < d) ? n : d;
                c[ch*8 +: 8] = 8'((tc > sc) ? sc + mv : sc - mv);
                if (d > maxd) maxd = d;
            end
            idle0 = maxd * tp;
            rdy = (j >= idle0);
        end
`ifdef RGB_CTRL_TIMEOUT_EN
        if (j >= idle0 + TD * TO) return {1'b1, 1'b0, 24'h0};
`endif
        return {rdy, 1'b1, c};
    endfunction

    function automatic int fade_len(input logic [23:0] s, input logic [23:0] t, input int p);
        int d, maxd;
        maxd = 0;
        for (int ch = 0; ch < 3; ch++) begin
            d = int'(s[ch*8 +: 8]) - int'(t[ch*8 +: 8]);
            if (d < 0) d = -d;
            if (d > maxd) maxd = d;
        end
        return maxd * TD * ((p == 0) ? 1 : p);
    endfunction

    function automatic logic [23:0] rand_color();
        logic [23:0] c;
        for (int ch = 0; ch < 3; ch++) begin
            case ($urandom_range(0, 3))
                0:       c[ch*8 +: 8] = 8'h00;
                1:       c[ch*8 +: 8] = 8'hFF;
                default: c[ch*8 +: 8] = 8'($urandom_range(0, 255));
            endcase
        end
        return c;
    endfunction

    function automatic logic [23:0] near_color(input logic [23:0] s);
        logic [23:0] c;
        int v;
        for (int ch = 0; ch < 3; ch++) begin
            v = int'(s[ch*8 +: 8]) + $urandom_range(0, 6) - 3;
            if (v < 0) v = 0;
            if (v > 255) v = 255;
            c[ch*8 +: 8] = 8'(v);
        end
        return c;
    endfunction

    task automatic tick1();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [25:0] obs, input logic [25:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed {rdy,en,color}=%h expected %h", tag, obs, exp);
        end
    endtask

    task automatic send(input int m, input logic [23:0] c, input int p);
        int budget;
        budget = 2000;
        bus.cmd_valid  = 1'b1;
        bus.cmd_mode   = 2'(m);
        bus.cmd_color  = c;
        bus.cmd_period = 8'(p);
        while (bus.cmd_ready !== 1'b1 && budget > 0) begin
            tick1();
            budget--;
        end
        check("accept_ready", {25'd0, bus.cmd_ready}, 26'd1);
        tick1();
        bus.cmd_valid = 1'b0;
        $display("cmd mode=%0d color=%h period=%0d", m, c, p);
    endtask

    // Checks outputs at j = 0..n after acceptance; returns the colour seen at j = n
    task automatic watch(input string tag, input int m, input logic [23:0] s,
                         input logic [23:0] t, input int p, input int n,
                         output logic [23:0] last);
        logic [25:0] exp;
        exp = '0;
        for (int j = 0; j <= n; j++) begin
            if (j > 0) tick1();
            exp = model(m, s, t, p, j);
            check(tag, {bus.cmd_ready, bus.en, bus.color}, exp);
        end
        last = exp[23:0];
    endtask

    logic [23:0] cur;
    logic [23:0] tgt;
    int          m;
    int          p;
    int          n;

    initial begin
        n_cmp = 0;
        n_mis = 0;
        rst = 1'b1;
        bus.cmd_valid  = 1'b0;
        bus.cmd_mode   = 2'd0;
        bus.cmd_color  = 24'h0;
        bus.cmd_period = 8'd0;
        repeat (3) tick1();
        check("reset", {bus.cmd_ready, bus.en, bus.color}, {1'b1, 1'b0, 24'h0});
        rst = 1'b0;
        tick1();
        check("idle_off", {bus.cmd_ready, bus.en, bus.color}, {1'b1, 1'b0, 24'h0});

        send(MODE_SOLID, 24'h102030, 0);
        watch("solid", 1, 24'h0, 24'h102030, 0, 100, cur);

        send(MODE_BLINK, 24'hFF0000, 2);
        watch("blink", 2, cur, 24'hFF0000, 2, 40, cur);
        send(MODE_OFF, 24'h123456, 5);
        watch("off", 0, cur, 24'h123456, 5, 3, cur);

        // FADE with a SOLID command held pending until the fade completes
        send(MODE_SOLID, 24'h000000, 0);
        watch("solid0", 1, cur, 24'h000000, 0, 2, cur);
        send(MODE_FADE, 24'h030001, 1);
        bus.cmd_valid  = 1'b1;
        bus.cmd_mode   = 2'(MODE_SOLID);
        bus.cmd_color  = 24'h00AA00;
        bus.cmd_period = 8'd0;
        watch("fade_hold", 3, 24'h000000, 24'h030001, 1, 12, cur);
        tick1();
        bus.cmd_valid = 1'b0;
        check("held_solid", {bus.cmd_ready, bus.en, bus.color}, {1'b1, 1'b1, 24'h00AA00});
        cur = 24'h00AA00;

        send(MODE_SOLID, 24'h050505, 0);
        watch("solid5", 1, cur, 24'h050505, 0, 1, cur);
        send(MODE_FADE, 24'h050505, 3);
        watch("fade_same", 3, cur, 24'h050505, 3, 6, cur);
        send(MODE_SOLID, 24'hFFFFFF, 0);
        watch("solidFF", 1, cur, 24'hFFFFFF, 0, 1, cur);
        send(MODE_FADE, 24'hFFFFFF, 1);
        watch("fade_ff", 3, cur, 24'hFFFFFF, 1, 6, cur);
        send(MODE_FADE, 24'hFF00FE, 0);
        watch("fade_edge", 3, 24'hFFFFFF, 24'hFF00FE, 0, fade_len(24'hFFFFFF, 24'hFF00FE, 0) + 4, cur);

        // Reset mid-FADE and mid-BLINK_OFF
        send(MODE_FADE, 24'h808080, 3);
        watch("fade_pre_rst", 3, cur, 24'h808080, 3, 20, cur);
        rst = 1'b1;
        tick1();
        rst = 1'b0;
        check("rst_fade", {bus.cmd_ready, bus.en, bus.color}, {1'b1, 1'b0, 24'h0});
        send(MODE_BLINK, 24'h123456, 1);
        watch("blink_pre_rst", 2, 24'h0, 24'h123456, 1, 5, cur);
        rst = 1'b1;
        tick1();
        rst = 1'b0;
        check("rst_blink", {bus.cmd_ready, bus.en, bus.color}, {1'b1, 1'b0, 24'h0});
        cur = 24'h0;

`ifdef RGB_CTRL_TIMEOUT_EN
        send(MODE_SOLID, 24'h0000FF, 0);
        watch("to_solid", 1, cur, 24'h0000FF, 0, 16, cur);
        send(MODE_SOLID, 24'h0000FF, 0);
        watch("to_pre", 1, cur, 24'h0000FF, 0, 9, cur);
        send(MODE_SOLID, 24'h00FF00, 0);
        watch("to_restart", 1, cur, 24'h00FF00, 0, 14, cur);
        send(MODE_SOLID, 24'h000000, 0);
        send(MODE_FADE, 24'h000005, 1);
        watch("to_fade", 3, 24'h000000, 24'h000005, 1, 34, cur);
`endif

        for (int it = 0; it < 40; it++) begin
            m = $urandom_range(0, 3);
            p = $urandom_range(0, 3);
            tgt = (m == 3) ? near_color(cur) : rand_color();
            n = (m == 3) ? fade_len(cur, tgt, p) + $urandom_range(0, 5) : $urandom_range(3, 40);
            send(m, tgt, p);
            watch("random", m, cur, tgt, p, n, cur);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule

// File: doc/rgb_ctrl.md
Name: rgb_ctrl

Overview:
Sequencer that drives the packed colour word and enable of the on-board RGB PWM LED driver.
- Accepts colour commands from the system over a valid/ready handshake.
- Plays them out as off, solid, blink or linear fade, timed by an internal tick prescaler.
- Sits between the robot status logic and the RGB PWM block.
- Owns the colour/enable inputs of the PWM block exclusively.

Parameters:
- NBPC, 8, bits per colour channel; colour word is 3*NBPC bits, packed {R,G,B} with R in the MSBs.
- TICK_DIV, 120000, clk cycles per timing tick (10 ms at 12 MHz); must be >= 2.
- TIMEOUT_TICKS, 255, ticks without an accepted command before auto-off (optional feature only).

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous reset, active-high.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  controller can accept a command.
- cmd_mode  in  2  0=OFF, 1=SOLID, 2=BLINK, 3=FADE.
- cmd_color  in  3*NBPC  target colour.
- cmd_period  in  8  blink half-period, or fade step interval, in ticks; 0 is treated as 1.
- color  out  3*NBPC  colour word to the PWM block.
- en  out  1  enable to the PWM block.

Behaviour:
Clocking and reset:
- Reset is clk/rst: synchronous, active-high. rst has priority over every other event.
- Reset values: state S_OFF, color=0, en=0, cmd_ready=1; prescaler, tick counter and stored command cleared.

Handshake and latency:
- A command is accepted on a rising edge where cmd_valid & cmd_ready.
- cmd_mode, cmd_color and cmd_period are latched at acceptance.
- color and en are registered; the new values appear in the cycle after acceptance (1-cycle latency).
- cmd_ready=0 only in S_FADE. Commands preempt OFF, SOLID and BLINK immediately.

Timing:
- Prescaler counts 0..TICK_DIV-1 and pulses tick for one cycle at TICK_DIV-1, then wraps.
- Prescaler and tick counter restart at 0 on every accepted command. The first tick therefore occurs TICK_DIV cycles after acceptance.
- Period P = max(cmd_period, 1).

States:
- S_OFF: color=0, en=0.
- S_SOLID: color=latched colour, en=1. Holds indefinitely.
- S_BLINK_ON: color=latched colour, en=1. After P ticks -> S_BLINK_OFF.
- S_BLINK_OFF: color=0, en=1. After P ticks -> S_BLINK_ON.
- Blink always starts in S_BLINK_ON.
- S_FADE: en=1; the start value is the colour currently on the color output.
  - Every P ticks, each channel independently moves 1 LSB toward its target. Channels already at target hold.
  - When all three channels equal the target -> S_SOLID, and cmd_ready rises in that same cycle.
  - FADE with target equal to the current colour -> S_SOLID in the cycle after acceptance, with no tick wait.

Width and boundary rules:
- Channel arithmetic is unsigned NBPC-bit; steps never overshoot or wrap, e.g. 0xFF is never stepped up and 0x00 never stepped down.
- The tick counter is 8 bits and compares against P; it clears on each phase or step event.
- cmd_valid while cmd_ready=0: the command is not accepted. The requester must hold cmd_valid until ready.
- cmd_period=0 behaves exactly like cmd_period=1.
- rst during S_FADE or blink: immediate return to reset values on the next edge.

Optional Feature:
Macro RGB_CTRL_TIMEOUT_EN.
- Defined: an 8-bit idle counter increments per tick in S_SOLID, S_BLINK_ON and S_BLINK_OFF, and clears on every accepted command.
  - On reaching TIMEOUT_TICKS -> S_OFF (color=0, en=0).
  - S_FADE does not time out; the counter is held at 0 there.
- Undefined: no idle counter. SOLID and BLINK persist until the next command or reset.

Decomposition:
- Shared package rgb_pkg holds:
  - mode encodings MODE_OFF, MODE_SOLID, MODE_BLINK, MODE_FADE (2 bits);
  - the state encodings;
  - the macro for colour-word width, 3*NBPC.
- Sub-module rgb_ctrl_step: one NBPC-bit channel stepper (current, target, step strobe -> next value, done flag), instantiated three times inside rgb_ctrl.
- Prescaler, timers and FSM stay in rgb_ctrl.

Test Plan (NBPC=8, TICK_DIV=4):
- Reset, then SOLID 0x102030 P=0 -> next cycle color=0x102030, en=1, cmd_ready=1; held for 100 cycles.
- BLINK 0xFF0000 P=2 -> color=0xFF0000 for 8 cycles, then 0x000000 with en=1 for 8 cycles, repeating; OFF command -> color=0, en=0 next cycle.
- From SOLID 0x000000, FADE 0x030001 P=1:
  - color goes 0x010001, 0x020001, 0x030001 at 4-cycle spacing;
  - cmd_ready=0 throughout, and rises in the cycle color reaches 0x030001 and the state becomes SOLID;
  - a SOLID command held during the fade is accepted only then.
- FADE from 0x050505 to 0x050505 -> S_SOLID the next cycle with no tick wait; FADE 0xFF -> 0xFF per channel causes no wrap.
- rst asserted mid-FADE and mid-BLINK_OFF -> next cycle color=0, en=0, cmd_ready=1.
- RGB_CTRL_TIMEOUT_EN with TIMEOUT_TICKS=3: SOLID 0x0000FF -> OFF 12 cycles after acceptance. A new command at cycle 10 restarts the count; no timeout during FADE.
